// File: rtl/z_buffer_pkg.sv
// Shared definitions for the z-buffer sequencing controller: FSM states,
// default field widths and pixel bus field offsets.
package z_buffer_pkg;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    CMP,
    WR
  } state_t;

  localparam int unsigned DEF_ADDR_WIDTH  = 4;
  localparam int unsigned DEF_DEPTH_WIDTH = 8;
  localparam int unsigned DEF_COLOR_WIDTH = 8;

  // Pixel bus is packed {addr, depth, color} with color in the LSBs.
  function automatic int unsigned depth_lsb(input int unsigned color_w);
    return color_w;
  endfunction

  function automatic int unsigned addr_lsb(input int unsigned depth_w,
                                           input int unsigned color_w);
    return depth_w + color_w;
  endfunction

endpackage

// File: rtl/z_buffer_if.sv
// Pixel handshake between the contention tree (master) and the z-buffer
// controller (slave).
interface z_buffer_if #(
  parameter int unsigned PIXEL_WIDTH = 20
);
  logic [PIXEL_WIDTH-1:0] pix_out;
  logic                   send_z_buffer;
  logic                   rdy_z_buffer;

  modport master (output pix_out, output send_z_buffer, input  rdy_z_buffer);
  modport slave  (input  pix_out, input  send_z_buffer, output rdy_z_buffer);
endinterface

// File: rtl/z_buffer_fifo.sv
// Two-entry pixel FIFO with occupancy count and a sticky overflow flag that
// records any push arriving while both slots are occupied.
module z_buffer_fifo #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count,
  output logic             empty,
  output logic             overflow
);

  logic [WIDTH-1:0] slot [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             full;
  logic             accept;

  assign full   = (count == 2'd2);
  assign empty  = (count == 2'd0);
  // Fullness is judged before any same-cycle pop, so a push into a full FIFO drops.
  assign accept = push && !full;
  assign head   = slot[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot[0]  <= '0;
      slot[1]  <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        slot[wr_ptr] <= din;
        wr_ptr       <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/z_buffer_ctrl.sv
// Z-buffer sequencer: buffers arbitrated pixels and runs a read, depth compare
// and conditional write per pixel against a 1-cycle-latency SRAM; sweeps clear.
module z_buffer_ctrl
  import z_buffer_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned           DEPTH_WIDTH = DEF_DEPTH_WIDTH,
  parameter int unsigned           COLOR_WIDTH = DEF_COLOR_WIDTH,
  parameter int unsigned           PIXEL_WIDTH = ADDR_WIDTH + DEPTH_WIDTH + COLOR_WIDTH,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  z_buffer_if.slave                          pix_if,
  input  logic                               clear_start,
  output logic                               busy,
  output logic                               clear_done,
  output logic                               overflow,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic                               mem_rd_en,
  input  logic [DEPTH_WIDTH+COLOR_WIDTH-1:0] mem_rdata,
  output logic                               mem_wr_en,
  output logic [DEPTH_WIDTH+COLOR_WIDTH-1:0] mem_wdata
);

  localparam int unsigned DLSB = depth_lsb(COLOR_WIDTH);
  localparam int unsigned ALSB = addr_lsb(DEPTH_WIDTH, COLOR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0]  CNT_LAST  = '1;
  localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = '1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    clear_pending;
  logic                    armed;
  logic                    clear_req;
  logic                    closer;
  logic                    pop;

  logic [PIXEL_WIDTH-1:0]  head;
  logic [1:0]              fifo_count;
  logic                    fifo_empty;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [DEPTH_WIDTH-1:0]  head_depth;
  logic [COLOR_WIDTH-1:0]  head_color;
  logic [DEPTH_WIDTH-1:0]  rd_depth;
  logic                    rdata_color_unused;

  z_buffer_fifo #(
    .WIDTH (PIXEL_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pix_if.send_z_buffer),
    .din      (pix_if.pix_out),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  assign head_addr          = head[ALSB +: ADDR_WIDTH];
  assign head_depth         = head[DLSB +: DEPTH_WIDTH];
  assign head_color         = head[0 +: COLOR_WIDTH];
  assign rd_depth           = mem_rdata[COLOR_WIDTH +: DEPTH_WIDTH];
  assign rdata_color_unused = ^mem_rdata[COLOR_WIDTH-1:0];

  // Ties keep the stored pixel, so only a strictly closer depth is written.
  assign closer    = head_depth < rd_depth;
  assign clear_req = clear_start || clear_pending;

  assign pix_if.rdy_z_buffer = (fifo_count == 2'd0) && (state != CLEAR);
  assign busy                = (state != IDLE) || !fifo_empty;

  // armed holds the sweep off while reset is asserted so no write strobe
  // escapes during reset; the sweep begins on the first edge after release.
  always_comb begin
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = head_addr;
    mem_wdata  = {head_depth, head_color};
    clear_done = 1'b0;
    pop        = 1'b0;
    unique case (state)
      CLEAR: begin
        mem_addr   = clr_cnt;
        mem_wdata  = {DEPTH_MAX, CLEAR_COLOR};
        mem_wr_en  = armed;
        clear_done = armed && (clr_cnt == CNT_LAST);
      end
      IDLE:    mem_rd_en = !clear_req && !fifo_empty;
      CMP:     pop       = !closer;
      WR: begin
        mem_wr_en = 1'b1;
        pop       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= CLEAR;
      clr_cnt       <= '0;
      clear_pending <= 1'b0;
      armed         <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (state != IDLE && clear_start) clear_pending <= 1'b1;
      unique case (state)
        CLEAR: begin
          if (armed) begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
            if (clr_cnt == CNT_LAST) state <= IDLE;
          end
        end
        IDLE: begin
          if (clear_req) begin
            state         <= CLEAR;
            clear_pending <= 1'b0;
          end else if (!fifo_empty) begin
            state <= CMP;
          end
        end
        CMP:     state <= closer ? WR : IDLE;
        WR:      state <= IDLE;
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
